// File: rtl/soc_mem_ctrl_if.sv
// Core-side memory bus for soc_mem_ctrl: valid/ready request channel with
// byte strobes and a one-cycle read-data return.
interface soc_mem_ctrl_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/soc_mem_ctrl.sv
// Memory controller: on-chip RAM with programmable wait states, GPIO and
// status MMIO registers, and a timeout-terminated error path for unmapped addresses.
module soc_mem_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int RAM_WAIT  = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic           clk,
  input  logic           reset,
  soc_mem_ctrl_if.slave  bus,
  output logic [31:0]    gpio_out,
  output logic           err_flag,
  output logic [15:0]    store_count
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [2:0] {RG_RAM, RG_GPIO, RG_SCNT, RG_ESTAT, RG_NONE} region_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          accept;
  logic          resp_entry;

  region_t       dec_region, region_q, cur_region;
  logic [7:0]    load_cnt;
  logic [AW-1:0] idx_q, cur_idx;
  logic [31:0]   wdata_q, cur_wdata;
  logic [3:0]    wstrb_q, cur_wstrb;
  logic          cur_write;

  logic [31:0]   ram [MEM_WORDS];
  logic [31:0]   rd_value;
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic [15:0]   scnt_q;

  logic          unused_bits;
  assign unused_bits = ^{bus.mem_instr, bus.mem_addr[1:0]};

  // Address decode of the live request; byte offset bits are ignored.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dec_region = RG_NONE;
    load_cnt   = 8'd0;
    if (bus.mem_addr[31:AW+2] == '0)              dec_region = RG_RAM;
    else if (bus.mem_addr[31:2] == 30'h0400_0000) dec_region = RG_GPIO;
    else if (bus.mem_addr[31:2] == 30'h0400_0001) dec_region = RG_SCNT;
    else if (bus.mem_addr[31:2] == 30'h0400_0002) dec_region = RG_ESTAT;
    case (dec_region)
      RG_RAM:  load_cnt = 8'(RAM_WAIT);
      RG_NONE: load_cnt = 8'(TIMEOUT - 1);
      default: load_cnt = 8'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          accept  = 1'b1;
          cnt_d   = load_cnt;
          state_d = (load_cnt != 8'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!bus.mem_valid) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    resp_entry = (state_d == ST_RESP);
  end

  // Zero-wait accesses complete on the accept edge, before the request registers hold them.
  always_comb begin
    cur_region = (state_q == ST_IDLE) ? dec_region                 : region_q;
    cur_idx    = (state_q == ST_IDLE) ? bus.mem_addr[AW+1:2]       : idx_q;
    cur_wdata  = (state_q == ST_IDLE) ? bus.mem_wdata              : wdata_q;
    cur_wstrb  = (state_q == ST_IDLE) ? bus.mem_wstrb              : wstrb_q;
    cur_write  = (cur_wstrb != 4'b0000);
  end

  always_comb begin
    rd_value = 32'hDEAD_BEEF;
    case (cur_region)
      RG_RAM:   rd_value = ram[cur_idx];
      RG_GPIO:  rd_value = gpio_out;
      RG_SCNT:  rd_value = {16'h0000, scnt_q};
      RG_ESTAT: rd_value = {31'h0, err_flag};
      default:  rd_value = 32'hDEAD_BEEF;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      region_q <= RG_NONE;
      idx_q    <= '0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        region_q <= dec_region;
        idx_q    <= bus.mem_addr[AW+1:2];
        wdata_q  <= bus.mem_wdata;
        wstrb_q  <= bus.mem_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
      gpio_out <= 32'h0;
      err_flag <= 1'b0;
      scnt_q   <= 16'h0;
    end else begin
      ready_q <= resp_entry;
      rdata_q <= resp_entry ? rd_value : 32'h0;
      if (resp_entry) begin
        if (cur_region == RG_GPIO) begin
          for (int i = 0; i < 4; i++)
            if (cur_wstrb[i]) gpio_out[8*i +: 8] <= cur_wdata[8*i +: 8];
        end
        if (cur_write && cur_region != RG_NONE && scnt_q != 16'hFFFF)
          scnt_q <= scnt_q + 16'd1;
        // A completing unmapped access takes priority over an ERRSTAT clear.
        if (cur_region == RG_NONE)
          err_flag <= 1'b1;
        else if (cur_region == RG_ESTAT && cur_wstrb[0] && cur_wdata[0])
          err_flag <= 1'b0;
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto plain memory macros.
  always_ff @(posedge clk) begin
    if (resp_entry && cur_region == RG_RAM) begin
      for (int i = 0; i < 4; i++)
        if (cur_wstrb[i]) ram[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign store_count   = scnt_q;

endmodule

// File: tb/tb_soc_mem_ctrl.sv
// Randomized bench for soc_mem_ctrl: every access is predicted by a
// transaction-level model of the address map, latencies and side effects.
module tb_soc_mem_ctrl;

  localparam int MEM_WORDS = 1024;
  localparam int RAM_WAIT  = 1;
  localparam int TIMEOUT   = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_out;
  logic        err_flag;
  logic [15:0] store_count;

  soc_mem_ctrl_if bus ();

  soc_mem_ctrl #(
    .MEM_WORDS (MEM_WORDS),
    .RAM_WAIT  (RAM_WAIT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .gpio_out    (gpio_out),
    .err_flag    (err_flag),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [31:0] ram_m [int];
  logic [31:0] gpio_m;
  int          cnt_m;
  logic        err_m;

  logic [31:0] last_rd;
  int          last_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic void bump();
    if (cnt_m < 65535) cnt_m++;
  endfunction

  // Predicts read data and latency, then applies the access's side effects.
  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output int lat, output logic chk_rd);
    int unsigned idx;
    logic        wr;
    logic [31:0] wa;
    wr     = (ws != 4'b0000);
    wa     = a & 32'hFFFF_FFFC;
    chk_rd = !wr;
    rd     = 32'h0;
    if (a < 32'(MEM_WORDS * 4)) begin
      idx = a >> 2;
      lat = RAM_WAIT + 1;
      if (ram_m.exists(idx)) rd = ram_m[idx];
      else chk_rd = 1'b0;
      if (wr) begin
        if (ram_m.exists(idx)) ram_m[idx] = merge(ram_m[idx], wd, ws);
        else if (ws == 4'hF) ram_m[idx] = wd;
        bump();
      end
    end else if (wa == 32'h1000_0000) begin
      lat = 1; rd = gpio_m;
      if (wr) begin gpio_m = merge(gpio_m, wd, ws); bump(); end
    end else if (wa == 32'h1000_0004) begin
      lat = 1; rd = {16'h0, 16'(cnt_m)};
      if (wr) bump();
    end else if (wa == 32'h1000_0008) begin
      lat = 1; rd = {31'h0, err_m};
      if (wr) begin
        if (ws[0] && wd[0]) err_m = 1'b0;
        bump();
      end
    end else begin
      lat = TIMEOUT; rd = 32'hDEAD_BEEF; chk_rd = 1'b1;
      err_m = 1'b1;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    bus.mem_valid = 1'b1;
    bus.mem_instr = 1'($urandom_range(0, 1));
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
  endtask

  task automatic wait_ready(output int lat, output logic [31:0] rd, output logic idle_bad);
    logic done;
    done = 1'b0; lat = 0; rd = 32'h0; idle_bad = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_ready) begin
        rd   = bus.mem_rdata;
        done = 1'b1;
      end else if (bus.mem_rdata != 32'h0) idle_bad = 1'b1;
    end
    if (!done) begin
      check("ready_timeout", 32'h0, 32'h1);
      lat = -1;
    end
  endtask

  task automatic check_state();
    check("gpio_out", gpio_out, gpio_m);
    check("err_flag", {31'h0, err_flag}, {31'h0, err_m});
    check("store_count", {16'h0, store_count}, 32'(cnt_m));
  endtask

  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] exp_rd, rd;
    int          exp_lat, lat;
    logic        chk_rd, idle_bad;
    model(a, wd, ws, exp_rd, exp_lat, chk_rd);
    @(negedge clk);
    drive(a, wd, ws);
    wait_ready(lat, rd, idle_bad);
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata_idle", {31'h0, idle_bad}, 32'h0);
    if (chk_rd) check("rdata", rd, exp_rd);
    check_state();
    last_rd  = rd;
    last_lat = lat;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse", {31'h0, bus.mem_ready}, 32'h0);
    check("rdata_drop", bus.mem_rdata, 32'h0);
  endtask

  task automatic count_readies(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) seen++;
    end
  endtask

  initial begin
    logic [31:0] a, wd, e_rd1, e_rd2, rd;
    logic [3:0]  ws;
    int          e_lat, lat, seen, kind, idx;
    logic        chk1, chk2, idle_bad;

    gpio_m = 32'h0; cnt_m = 0; err_m = 1'b0;
    reset = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0;
    bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("rst_rdata", bus.mem_rdata, 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_err", {31'h0, err_flag}, 32'h0);
    check("rst_count", {16'h0, store_count}, 32'h0);
    // Release just after an edge so the next edge is the first one out of reset.
    @(posedge clk); #2;
    reset = 1'b1;

    // Directed scenarios
    xact(32'h1000_0000, 32'hCAFE_0001, 4'hF);
    check("gpio_cafe", gpio_out, 32'hCAFE_0001);
    check("gpio_lat", 32'(last_lat), 32'd1);
    xact(32'h1000_0004, 32'h0, 4'h0);
    check("storecnt_one", last_rd, 32'h0000_0001);
    xact(32'h0000_0010, 32'hA5A5_1234, 4'hF);
    xact(32'h0000_0010, 32'h0, 4'h0);
    check("ram_word", last_rd, 32'hA5A5_1234);
    check("ram_lat", 32'(last_lat), 32'd2);
    xact(32'h0000_0010, 32'h0000_FF00, 4'b0010);
    xact(32'h0000_0013, 32'h0, 4'h0);
    check("ram_byte", last_rd, 32'hA5A5_FF34);
    xact(32'h2000_0000, 32'h0, 4'h0);
    check("unmapped_rdata", last_rd, 32'hDEAD_BEEF);
    check("unmapped_lat", 32'(last_lat), 32'd15);
    check("unmapped_err", {31'h0, err_flag}, 32'h1);
    xact(32'h1000_0008, 32'h0, 4'h0);
    check("errstat_read", last_rd, 32'h1);
    xact(32'h1000_0008, 32'h1, 4'h1);
    check("errstat_clear", {31'h0, err_flag}, 32'h0);
    xact(32'(MEM_WORDS * 4), 32'h0, 4'h0);
    check("ram_end_unmapped", last_rd, 32'hDEAD_BEEF);

    // Back-to-back: next request presented during the RESP cycle
    model(32'h1000_0000, 32'h0BAD_F00D, 4'hF, e_rd1, e_lat, chk1);
    model(32'h1000_0004, 32'h0, 4'h0, e_rd2, e_lat, chk2);
    @(negedge clk);
    drive(32'h1000_0000, 32'h0BAD_F00D, 4'hF);
    wait_ready(lat, rd, idle_bad);
    @(negedge clk);
    drive(32'h1000_0004, 32'h0, 4'h0);
    wait_ready(lat, rd, idle_bad);
    check("b2b_gap", 32'(lat), 32'd2);
    check("b2b_rdata", rd, e_rd2);
    @(negedge clk);
    bus.mem_valid = 1'b0;

    // Populate both ends of RAM, then random traffic
    for (int i = 0; i < 8; i++) begin
      xact(32'(i * 4), $urandom, 4'hF);
      xact(32'((MEM_WORDS - 8 + i) * 4), $urandom, 4'hF);
    end
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 99);
      wd   = $urandom;
      ws   = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
      if (kind < 60) begin
        idx = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7)
                                          : MEM_WORDS - 8 + $urandom_range(0, 7);
        a = 32'(idx * 4 + $urandom_range(0, 3));
      end else if (kind < 85) begin
        a = 32'h1000_0000 + 32'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 3))
          0: a = 32'(MEM_WORDS * 4 + $urandom_range(0, 3));
          1: a = 32'h1000_000C;
          2: a = 32'h2000_0000 + ($urandom & 32'h00FF_FFFC);
          default: a = 32'hFFFF_FFFC;
        endcase
      end
      xact(a, wd, ws);
    end

    // Reset during the wait phase of a RAM write
    xact(32'h1000_0000, 32'h1234_5678, 4'hF);
    xact(32'h3000_0000, 32'h0, 4'h0);
    @(negedge clk);
    drive(32'h0000_000C, 32'h1111_2222, 4'hF);
    @(posedge clk); #1;
    check("mid_wait_no_ready", {31'h0, bus.mem_ready}, 32'h0);
    reset = 1'b0;
    #1;
    gpio_m = 32'h0; err_m = 1'b0; cnt_m = 0;
    check("async_rst_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("async_rst_rdata", bus.mem_rdata, 32'h0);
    check_state();
    @(negedge clk);
    bus.mem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    count_readies(5, seen);
    check("post_rst_no_ready", 32'(seen), 32'h0);
    xact(32'h0000_000C, 32'h0, 4'h0);

    // Abort: valid dropped while waiting
    @(negedge clk);
    drive(32'h0000_0004, 32'h7777_7777, 4'hF);
    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    count_readies(6, seen);
    check("abort_ram_no_ready", 32'(seen), 32'h0);
    check_state();
    xact(32'h0000_0004, 32'h0, 4'h0);
    @(negedge clk);
    drive(32'h2000_0040, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    count_readies(TIMEOUT + 2, seen);
    check("abort_unmapped_no_ready", 32'(seen), 32'h0);
    check_state();

    // Counter saturation: preload near the top, then keep writing
    @(negedge clk);
    force dut.scnt_q = 16'hFFFC;
    @(negedge clk);
    release dut.scnt_q;
    cnt_m = 32'hFFFC;
    for (int i = 0; i < 6; i++) xact(32'h1000_0000 + 32'(i % 3) * 4, $urandom, 4'($urandom_range(1, 15)));
    check("count_saturated", {16'h0, store_count}, 32'h0000_FFFF);
    xact(32'h1000_0004, 32'h0, 4'h0);
    check("storecnt_sat_read", last_rd, 32'h0000_FFFF);
    @(negedge clk);
    drive(32'h0000_0020, 32'h5555_5555, 4'hF);
    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    count_readies(4, seen);
    check("abort_sat_no_ready", 32'(seen), 32'h0);
    check("abort_sat_count", {16'h0, store_count}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_mem_ctrl.md
SOC_MEM_CTRL -- requirements
Module: soc_mem_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 1024, RAM depth in 32-bit words (power of two).
REQ-002 Parameter RAM_WAIT, default 1, extra wait cycles on RAM accesses (0..15).
REQ-003 Parameter TIMEOUT, default 15, cycles before an unmapped access is error-terminated (1..255).
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 mem_valid  in  1  core request valid; held until mem_ready.
REQ-007 mem_instr  in  1  request is an instruction fetch; informational, no behavioural effect.
REQ-008 mem_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 mem_wdata  in  32  write data.
REQ-010 mem_wstrb  in  4  byte write enables; 4'b0000 = read.
REQ-011 mem_ready  out  1  one-cycle completion pulse.
REQ-012 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-013 gpio_out  out  32  GPIO output register.
REQ-014 err_flag  out  1  sticky unmapped-access error.
REQ-015 store_count  out  16  count of completed mapped writes.

Function
REQ-016 Address map: RAM 0x0000_0000..MEM_WORDS*4-1; GPIO 0x1000_0000 (RW); STORECNT 0x1000_0004 (RO); ERRSTAT 0x1000_0008 (bit0=err_flag, write 1 to bit0 clears); all else unmapped.
REQ-017 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-018 IDLE: mem_valid=1 samples request (addr, wdata, wstrb registered), decodes region, loads wait counter: RAM=RAM_WAIT, MMIO=0, unmapped=TIMEOUT-1; goes to WAIT if counter>0 else RESP.
REQ-019 WAIT: counter decrements each cycle; at 0 goes to RESP.
REQ-020 RESP: mem_ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 Latency (first cycle mem_valid high in IDLE to mem_ready high): RAM = RAM_WAIT+1, MMIO = 1, unmapped = TIMEOUT cycles.
REQ-022 Back-to-back: IDLE in the cycle after RESP accepts a new request; minimum 2 cycles between mem_ready pulses.
REQ-023 mem_valid dropping in WAIT: abort to IDLE, no mem_ready, no write, no counter/flag update.
REQ-024 Writes commit on the RESP-entry edge, byte lane i written iff wstrb[i]=1; reads return full word regardless of strobes.
REQ-025 RAM index = addr[log2(MEM_WORDS)+1:2]; RAM contents are not reset.
REQ-026 GPIO write honours byte strobes; read returns gpio_out.
REQ-027 STORECNT writes ignored (still complete with mem_ready); read returns {16'h0, store_count}.
REQ-028 store_count increments by 1 per completed write (wstrb!=0) to any mapped address, saturating at 0xFFFF.
REQ-029 Unmapped access: mem_rdata=0xDEADBEEF, write dropped, err_flag set on RESP-entry edge.
REQ-030 ERRSTAT write with wdata[0]=1 and wstrb[0]=1 clears err_flag; unmapped access completing same edge wins (flag stays 1).
REQ-031 mem_rdata = 0 whenever mem_ready=0.

Reset
REQ-032 reset=0 forces asynchronously: state IDLE, mem_ready=0, mem_rdata=0, gpio_out=0, err_flag=0, store_count=0, wait counter=0.
REQ-033 reset asserted mid-transaction discards it; no write commits, no mem_ready after release until a new request.
REQ-034 First request accepted on the first rising edge with reset=1 and mem_valid=1.

Verification
REQ-035 RAM write 0x0000_0010 wdata 0xA5A5_1234 wstrb 1111, then read -> ready 2 cycles after valid (RAM_WAIT=1), rdata 0xA5A5_1234, store_count=1.
REQ-036 Byte write 0x0000_0010 wstrb 0010 wdata 0x0000_FF00 over previous -> read 0xA5A5_FF34.
REQ-037 GPIO write 0xCAFE_0001, then read STORECNT -> gpio_out 0xCAFE_0001 after ready, STORECNT reads 0x0000_0001 (fresh reset), latency 1.
REQ-038 Read 0x2000_0000 -> ready exactly 15 cycles after valid, rdata 0xDEADBEEF, err_flag=1; write 0x1 to ERRSTAT -> err_flag=0.
REQ-039 reset pulled low during WAIT of a RAM write -> no ready, target word unchanged on later read, all outputs at reset values.
REQ-040 70000 completed writes -> store_count saturates at 0xFFFF; valid dropped in WAIT -> no ready, count unchanged.
